// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider / clock-enable generator.
// Divides clk by any N >= 2 in square (near 50% duty) or single-pulse mode.
// A new divisor/mode is held in a shadow register and only commits at a
// period boundary (or while idle), so newclk never glitches.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - run enable; low holds the generator idle
//   div_in   - requested divisor (CNT_W bits)
//   mode_in  - requested mode (0 square, 1 pulse)
//   div_load - strobe capturing div_in/mode_in into the shadow registers
//   newclk   - divided clock / enable output (registered)
//   tick     - one-cycle pulse at each period start (registered)
//   pending  - shadow values waiting to commit (registered)
//   err      - one-cycle pulse when a load with div_in < 2 is rejected
module clk_div_prog #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_DIV  = 2,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             mode_in,
  input  logic             div_load,
  output logic             newclk,
  output logic             tick,
  output logic             pending,
  output logic             err
);

  localparam int unsigned     CW1     = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic             mode_q, mode_d;
  logic             smode_q, smode_d;
  logic             pending_d, newclk_d, tick_d, err_d;

  logic [CNT_W-1:0] half_c;
  logic             at_end_c;
  logic             load_ok_c;
  logic             commit_c;

  // High time of the square wave: ceil(div/2), computed one bit wider to avoid overflow.
  assign half_c    = CNT_W'((CW1'(div_q) + CW1'(1)) >> 1);
  assign at_end_c  = (cnt_q == (div_q - CNT_W'(1)));
  assign load_ok_c = div_load && (div_in >= CNT_W'(2));
  // Commit uses the registered pending, so a load on a boundary edge waits a period.
  assign commit_c  = pending && (!en || at_end_c);

  // Next-state and output computation
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sdiv_d    = sdiv_q;
    smode_d   = smode_q;
    pending_d = pending;
    newclk_d  = 1'b0;
    tick_d    = 1'b0;
    err_d     = 1'b0;

    // Outputs come from the pre-update count and active settings.
    if (en) begin
      newclk_d = mode_q ? (cnt_q == '0) : (cnt_q < half_c);
      tick_d   = (cnt_q == '0);
      cnt_d    = at_end_c ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (commit_c) begin
      div_d     = sdiv_q;
      mode_d    = smode_q;
      cnt_d     = '0;
      pending_d = 1'b0;
    end

    // A load overrides the commit's clear of pending; the old shadow was already used.
    if (load_ok_c) begin
      sdiv_d    = div_in;
      smode_d   = mode_in;
      pending_d = 1'b1;
    end

    err_d = div_load && !load_ok_c;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      mode_q  <= DEFAULT_MODE;
      sdiv_q  <= DEF_DIV;
      smode_q <= DEFAULT_MODE;
      pending <= 1'b0;
      newclk  <= 1'b0;
      tick    <= 1'b0;
      err     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      sdiv_q  <= sdiv_d;
      smode_q <= smode_d;
      pending <= pending_d;
      newclk  <= newclk_d;
      tick    <= tick_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: the stimulus process drives one vector
// per cycle and queues its hand-computed {newclk,tick,pending,err}; a monitor
// pops and compares after each rising edge.
module tb_clk_div_prog;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             mode_in;
  logic             div_load;
  logic             newclk;
  logic             tick;
  logic             pending;
  logic             err;

  int unsigned n_vec;
  int unsigned n_bad;
  int unsigned n_step;

  typedef struct {
    int unsigned idx;
    logic [3:0]  exp;
  } exp_t;

  exp_t exp_q[$];

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(2), .DEFAULT_MODE(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_in   (div_in),
    .mode_in  (mode_in),
    .div_load (div_load),
    .newclk   (newclk),
    .tick     (tick),
    .pending  (pending),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge and queue the result expected after the next rising edge.
  task automatic step(input logic e, input logic ld, input int unsigned dv,
                      input logic md, input logic [3:0] exp);
    exp_t item;
    @(negedge clk);
    en       = e;
    div_load = ld;
    div_in   = CNT_W'(dv);
    mode_in  = md;
    n_step   = n_step + 1;
    item.idx = n_step;
    item.exp = exp;
    exp_q.push_back(item);
  endtask

  task automatic check_now(input string name, input logic [3:0] exp);
    n_vec = n_vec + 1;
    if ({newclk, tick, pending, err} !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got {newclk,tick,pending,err}=%b want %b", name,
               {newclk, tick, pending, err}, exp);
    end
  endtask

  // Monitor: compare outputs one step after each rising edge.
  initial begin
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        item  = exp_q.pop_front();
        n_vec = n_vec + 1;
        if ({newclk, tick, pending, err} !== item.exp) begin
          n_bad = n_bad + 1;
          $display("FAIL vec%0d: got {newclk,tick,pending,err}=%b want %b",
                   item.idx, {newclk, tick, pending, err}, item.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_bad = 0; n_step = 0;
    rst_n = 1'b0; en = 1'b0; div_in = '0; mode_in = 1'b0; div_load = 1'b0;
    repeat (3) @(negedge clk);
    check_now("reset_state", 4'b0000);
    rst_n = 1'b1;

    // Defaults: divide by 2
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b0000);

    // Load div 3 square; commits at end of current div-2 period
    step(1, 1, 3, 0, 4'b1110); step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b1000); step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b1000); step(1, 0, 0, 0, 4'b0000);

    // Load div 5 pulse
    step(1, 1, 5, 1, 4'b1110); step(1, 0, 0, 0, 4'b1010); step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 4'b0000);

    // Rejected loads (div 1, div 0): err pulses, pattern unchanged
    step(1, 1, 1, 0, 4'b1101); step(1, 0, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 4'b0001); step(1, 0, 0, 0, 4'b0000); step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100);

    // Load 4, rejected load while pending, load 6 on the boundary edge:
    // 4 commits at that boundary, 6 at the following one
    step(1, 1, 4, 0, 4'b0010); step(1, 1, 0, 0, 4'b0011); step(1, 0, 0, 0, 4'b0010);
    step(1, 1, 6, 0, 4'b0010);
    step(1, 0, 0, 0, 4'b1110); step(1, 0, 0, 0, 4'b1010); step(1, 0, 0, 0, 4'b0010);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b1000); step(1, 0, 0, 0, 4'b1000);
    step(1, 0, 0, 0, 4'b0000); step(1, 0, 0, 0, 4'b0000); step(1, 0, 0, 0, 4'b0000);

    // Drop en at cnt 2, load div 4 while idle, resume
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b1000);
    step(0, 0, 0, 0, 4'b0000);
    step(0, 1, 4, 0, 4'b0010); step(0, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b1000);
    step(1, 0, 0, 0, 4'b0000); step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b1100);
    step(1, 1, 7, 1, 4'b1010);

    // Asynchronous reset mid-period discards pending load
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0;
    #1;
    check_now("async_reset", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 4'b1100); step(1, 0, 0, 0, 4'b0000); step(1, 0, 0, 0, 4'b1100);
    step(1, 0, 0, 0, 4'b0000);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expected results never checked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
